// File: rtl/dac_spi_arbiter.sv
// Arbitrates one DAC SPI master between the scan stream (req0, priority) and the config path (req1).
// Latency: a request sampled in IDLE at cycle N gives spi_start and ack at N+1; start spacing is 4 + busy length.
// Backpressure: requesters hold req/data until ack; no launch while spi_busy is high in IDLE.
// Optional watchdog on the SPI busy handshake: define DAC_SPI_ARB_TIMEOUT_EN.
module dac_spi_arbiter #(
  parameter int DATA_W      = 24,
  parameter int STARVE_MAX  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_busy,
  output logic              grant_id,
  output logic              active,
  output logic              timeout_err
);

  // Reject parameter values the 8-bit starvation counter / 16-bit watchdog cannot represent.
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dac_spi_arbiter: STARVE_MAX must be in 1..255");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
    $error("dac_spi_arbiter: TIMEOUT_CYC must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] starve_cnt;
  logic       starve_hit;
  logic       launch_ok;
  logic       pick1;
  logic       wd_expire;

  // The config path wins when scan is idle or once scan has had STARVE_MAX grants in a row.
  assign starve_hit = (starve_cnt == 8'(STARVE_MAX));
  assign pick1      = req1 && (!req0 || starve_hit);
  // A busy master left over from before a reset blocks new launches until it finishes.
  assign launch_ok  = (state == IDLE) && (req0 || req1) && !spi_busy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: launch, then follow the busy rise and fall of the SPI master.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch_ok) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_expire)     state_nxt = IDLE;
        else if (spi_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wd_expire || !spi_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: start and the winner's ack pulse in LAUNCH, active for the whole transfer.
  always_comb begin
    spi_start = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    active    = 1'b0;
    case (state)
      LAUNCH: begin
        spi_start = 1'b1;
        active    = 1'b1;
        ack0      = !grant_id;
        ack1      = grant_id;
      end
      WAIT_BUSY, WAIT_DONE: begin
        active = 1'b1;
      end
      default: begin
        active = 1'b0;
      end
    endcase
  end

  // Capture the winner's word and identity, and track how long req1 has been passed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_data   <= '0;
      grant_id   <= 1'b0;
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (launch_ok) begin
        spi_data <= pick1 ? data1 : data0;
        grant_id <= pick1;
      end
      if (!req1) begin
        starve_cnt <= '0;
      end else if (launch_ok) begin
        if (pick1)            starve_cnt <= '0;
        else if (!starve_hit) starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

`ifdef DAC_SPI_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        timeout_q;
  logic        in_wait;

  assign in_wait     = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign wd_expire   = in_wait && (wd_cnt == 16'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_q;

  // Watchdog: count cycles waiting on the master; expiry aborts the wait and latches the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (in_wait) wd_cnt <= wd_cnt + 16'd1;
      else         wd_cnt <= '0;
      if (wd_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter: scan, config, contention, withdrawal, reset mid-transfer, watchdog.
// Inputs and the SPI busy model are driven at the falling edge; outputs are sampled there too.
// Busy rises two falling edges after spi_start is seen, so a 20-cycle busy gives 23 active cycles.
module tb_dac_spi_arbiter;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0;
  logic          req1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          ack0;
  logic          ack1;
  logic          spi_start;
  logic [DW-1:0] spi_data;
  logic          spi_busy;
  logic          grant_id;
  logic          active;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_arbiter #(
    .DATA_W(DW),
    .STARVE_MAX(8),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .data0(data0),
    .ack0(ack0),
    .req1(req1),
    .data1(data1),
    .ack1(ack1),
    .spi_start(spi_start),
    .spi_data(spi_data),
    .spi_busy(spi_busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for spi_start; returns the number of falling edges waited.
  task automatic wait_start(input string tag, output int waited);
    waited = 0;
    while (!spi_start && waited < 200) begin
      tick();
      waited++;
    end
    check(tag, spi_start, 1'b1);
  endtask

  // Called at the falling edge where spi_start is seen; plays the SPI master and
  // returns at the first IDLE falling edge after the transfer.
  task automatic serve(input int blen, input int pulse_k,
                       output int act_len, output int n_start, output int n_ack1);
    act_len = active ? 1 : 0;
    n_start = 0;
    n_ack1  = 0;
    for (int k = 1; k <= blen + 3; k++) begin
      tick();
      act_len += active ? 1 : 0;
      n_start += spi_start ? 1 : 0;
      n_ack1  += ack1 ? 1 : 0;
      if (k == 2)        spi_busy = 1'b1;
      if (k == 2 + blen) spi_busy = 1'b0;
      if (k == pulse_k)     req1 = 1'b1;
      if (k == pulse_k + 1) req1 = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w, alen, nst, na1, t0, t1;
    logic [31:0] gvec, gexp;
    int acks0, acks1;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; spi_busy = 1'b0;
    data0 = '0; data1 = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_ack0", ack0, 1'b0);
    check("rst_ack1", ack1, 1'b0);
    check("rst_start", spi_start, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_grant", grant_id, 1'b0);
    check("rst_data", spi_data, 32'h0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_starve", dut.starve_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // Single scan word, 20-cycle busy.
    req0 = 1'b1; data0 = 24'h300ABC;
    wait_start("scan_start", w);
    check("scan_latency", w, 32'd1);
    check("scan_ack0", ack0, 1'b1);
    check("scan_ack1", ack1, 1'b0);
    check("scan_grant", grant_id, 1'b0);
    check("scan_data", spi_data, 32'h300ABC);
    req0 = 1'b0;
    serve(20, -5, alen, nst, na1);
    check("scan_active_len", alen, 32'd23);
    check("scan_extra_start", nst, 32'd0);
    check("scan_grant_hold", grant_id, 1'b0);

    // Config only.
    req1 = 1'b1; data1 = 24'h280001;
    wait_start("cfg_start", w);
    check("cfg_grant", grant_id, 1'b1);
    check("cfg_ack1", ack1, 1'b1);
    check("cfg_ack0", ack0, 1'b0);
    check("cfg_data", spi_data, 32'h280001);
    check("cfg_starve", dut.starve_cnt, 32'd0);
    req1 = 1'b0;
    serve(3, -5, alen, nst, na1);
    check("cfg_active_len", alen, 32'd6);

    // Contention: both held for 18 transfers, busy 2 cycles each.
    req0 = 1'b1; data0 = 24'h0A0A0A;
    req1 = 1'b1; data1 = 24'h0B0B0B;
    gvec = '0; acks0 = 0; acks1 = 0; t0 = 0;
    gexp = 32'h0002_0100;  // grants 8 and 17 (zero-based) go to requester 1
    for (int i = 0; i < 18; i++) begin
      wait_start("cont_start", w);
      gvec[i] = grant_id;
      acks0 += ack0 ? 1 : 0;
      acks1 += ack1 ? 1 : 0;
      if (i == 7) check("cont_starve_full", dut.starve_cnt, 32'd8);
      if (i == 8) check("cont_cfg_data", spi_data, 32'h0B0B0B);
      if (i == 0) t0 = cyc;
      if (i == 1) check("cont_spacing", cyc - t0, 32'd6);
      serve(2, -5, alen, nst, na1);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_grants", gvec, gexp);
    check("cont_ack0_cnt", acks0, 32'd16);
    check("cont_ack1_cnt", acks1, 32'd2);
    tick();

    // Withdrawn config request pulsed during WAIT_DONE.
    req0 = 1'b1; data0 = 24'h00C0DE;
    wait_start("wd_scan_start", w);
    req0 = 1'b0;
    serve(10, 6, alen, nst, na1);
    for (int k = 0; k < 5; k++) begin
      tick();
      nst += spi_start ? 1 : 0;
      na1 += ack1 ? 1 : 0;
    end
    check("withdraw_ack1", na1, 32'd0);
    check("withdraw_start", nst, 32'd0);

    // Reset in WAIT_DONE while the master stays busy.
    req0 = 1'b1; data0 = 24'hABCDEF;
    wait_start("rst_mid_start", w);
    req0 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) spi_busy = 1'b1;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_active", active, 1'b0);
    check("rst_mid_data", spi_data, 32'h0);
    check("rst_mid_grant", grant_id, 1'b0);
    req0 = 1'b1; data0 = 24'h123456;
    nst = 0;
    for (int k = 10; k <= 19; k++) begin
      tick();
      nst += spi_start ? 1 : 0;
      if (k == 19) spi_busy = 1'b0;
    end
    check("rst_mid_no_early_start", nst, 32'd0);
    tick();
    check("rst_mid_start_after_busy", spi_start, 1'b1);
    check("rst_mid_ack0", ack0, 1'b1);
    check("rst_mid_new_data", spi_data, 32'h123456);
    req0 = 1'b0;
    serve(2, -5, alen, nst, na1);

`ifdef DAC_SPI_ARB_TIMEOUT_EN
    // Watchdog: busy never rises.
    req0 = 1'b1; data0 = 24'h0F0F0F;
    wait_start("wdog_start", w);
    req0 = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 64) begin
        check("wdog_active_before", active, 1'b1);
        check("wdog_err_before", timeout_err, 1'b0);
      end
      if (k == 65) begin
        check("wdog_active_after", active, 1'b0);
        check("wdog_err_after", timeout_err, 1'b1);
      end
    end
    req0 = 1'b1; data0 = 24'h111111;
    wait_start("wdog_next_start", w);
    check("wdog_next_data", spi_data, 32'h111111);
    req0 = 1'b0;
    serve(2, -5, alen, nst, na1);
    check("wdog_err_sticky", timeout_err, 1'b1);
`else
    check("no_wdog_err", timeout_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
